// File: rtl/slice_pkg.sv
// slice_pkg: shared FSM encoding and default geometry for the slice merge/split paths.
package slice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam int SLICE_W_DEF = 2;
    localparam int SLICES_DEF  = 4;

endpackage

// File: rtl/slice_merge.sv
// slice_merge: packs SLICE_W-bit slices (LSB first) into one SLICES-slice word,
// with in_last ending a word early and a single registered output word buffer.
module slice_merge
    import slice_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int SLICES  = SLICES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SLICE_W-1:0]           in_slice,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SLICE_W*SLICES-1:0]    out_word,
    output logic [$clog2(SLICES+1)-1:0]  out_count
);

    localparam int CW    = $clog2(SLICES);
    localparam int CNT_W = $clog2(SLICES+1);
    localparam logic [CW-1:0] TOP = CW'(SLICES - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [CW-1:0]               r_cnt;
    logic [SLICE_W*SLICES-1:0]   r_word;
    logic [CNT_W-1:0]            r_count;
    logic                        w_in_fire;
    logic                        w_out_fire;
    logic                        w_done;

    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state == FULL);
    assign out_word   = r_word;
    assign out_count  = r_count;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    // A slice at the top position completes the word whether or not in_last is set.
    assign w_done     = w_in_fire & (in_last | (r_cnt == TOP));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_in_fire ? (w_done ? FULL : COLLECT) : IDLE;
            COLLECT: w_next = w_done ? FULL : COLLECT;
            FULL:    w_next = w_out_fire ? IDLE : FULL;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_out_fire) begin
                r_cnt   <= '0;
                r_word  <= '0;
                r_count <= '0;
            end else if (w_in_fire) begin
                for (int k = 0; k < SLICES; k++)
                    if (r_cnt == CW'(k))
                        r_word[k*SLICE_W +: SLICE_W] <= in_slice;
                if (w_done)
                    r_count <= CNT_W'(r_cnt) + 1'b1;
                else
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/slice_merge.md
SLICE_MERGE -- requirements
Module: slice_merge

Interface
REQ-001 Parameter SLICE_W, default 2, width of one input slice in bits.
REQ-002 Parameter SLICES, default 4, number of slices per output word; legal range 2..8.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  in_slice/in_last valid this cycle.
REQ-006 Port in_ready  output  1  block accepts a slice this cycle.
REQ-007 Port in_slice  input  SLICE_W  slice data; first accepted slice lands in LSBs.
REQ-008 Port in_last  input  1  accepted slice ends the word early (short word).
REQ-009 Port out_valid  output  1  out_word/out_count valid.
REQ-010 Port out_ready  input  1  downstream accepts the word.
REQ-011 Port out_word  output  SLICE_W*SLICES  reassembled word; unfilled slices zero.
REQ-012 Port out_count  output  $clog2(SLICES+1)  number of slices in out_word, 1..SLICES.

Function
REQ-013 Slice transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; word transfer where out_valid and out_ready are both 1.
REQ-014 FSM states SHALL be IDLE (no slices held), COLLECT (1..SLICES-1 slices held), FULL (word complete, out_valid=1).
REQ-015 IDLE -> COLLECT on a slice transfer with in_last=0; IDLE -> FULL on a transfer with in_last=1 (word of one slice).
REQ-016 COLLECT -> FULL when the accepted slice is slice SLICES-1 (zero-based) or carries in_last=1; otherwise remain in COLLECT.
REQ-017 FULL -> IDLE on word transfer.
REQ-018 Slice k (zero-based, counted since last word) SHALL be written to out_word bits [k*SLICE_W +: SLICE_W]; other bits hold.
REQ-019 in_ready SHALL be 1 in IDLE and COLLECT, 0 in FULL (no pass-through; one word of buffering).
REQ-020 out_valid SHALL be 1 exactly in FULL, registered, asserted the cycle after the completing slice transfer (latency 1 from last slice).
REQ-021 out_word and out_count SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 On word transfer the slice counter and out_word SHALL clear to 0 in the same edge.
REQ-023 in_last on slice SLICES-1 SHALL behave identically to in_last=0 on that slice.
REQ-024 in_slice/in_last SHALL be ignored when in_valid=0 or in_ready=0.
REQ-025 Slice counter SHALL never exceed SLICES-1 nor wrap; no path writes beyond the top slice.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, out_word 0, out_count 0, out_valid 0, in_ready 1.
REQ-027 Reset asserted mid-word or in FULL SHALL discard held slices; no word emitted after release.
REQ-028 First transfer after rst_n release SHALL be treated as slice 0.

Structure
REQ-029 State encoding (IDLE/COLLECT/FULL) and SLICE_W/SLICES defaults SHALL live in shared package slice_pkg, reusable by the split path.
REQ-030 Block SHALL be a single module with no sub-modules; no latches, no combinational in->out paths.

Verification
REQ-031 Reset, then slices 01,10,11,00 back-to-back, out_ready=1 -> out_word=8'b00111001, out_count=4, out_valid one cycle after 4th transfer, for exactly one cycle.
REQ-032 Slices 11,01 with in_last on 2nd -> out_word=8'b00000111, out_count=2; next word starts at slice 0.
REQ-033 Complete word with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_word/out_count unchanged, no slice lost; word taken on out_ready=1.
REQ-034 rst_n pulsed low after 2 of 4 slices -> outputs zero asynchronously; next 4 slices 10,10,10,10 -> out_word=8'b10101010, out_count=4.
REQ-035 Exhaustive sweep, all 2^SLICE_W values in every slice position with random in_valid/out_ready gaps -> scoreboard matches every word and count, no extra or missing words.
